// File: rtl/bitflip_scrub_monitor.sv
`default_nettype none
// ============================================================================
// bitflip_scrub_monitor: scans a pattern-preloaded flop array one block per
// cycle, reports/scrubs upset bits and counts them with a sticky alarm.
// Optional location reporting: BITFLIP_MON_LOC_EN. Revision: 1.0
// ============================================================================
module bitflip_scrub_monitor #(
    parameter int SPLIT_COUNT  = 8,
    parameter int DEPTH        = 2,
    parameter int PATTERN      = 0,
    parameter int CNT_W        = 16,
    parameter int ALARM_THRESH = 4,
    localparam int c_n_bits    = SPLIT_COUNT ** DEPTH,
    localparam int c_n_blocks  = SPLIT_COUNT ** (DEPTH - 1),
    localparam int c_idx_w     = (c_n_bits > 1) ? $clog2(c_n_bits) : 1,
    localparam int c_blk_w     = (c_n_blocks > 1) ? $clog2(c_n_blocks) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   inj_valid,
    input  logic [c_idx_w-1:0]     inj_idx,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [c_blk_w-1:0]     evt_block,
    output logic [SPLIT_COUNT-1:0] evt_mask,
    output logic [CNT_W-1:0]       flip_count,
    output logic                   alarm,
    output logic                   busy
);

    localparam int                 c_pop_w    = $clog2(SPLIT_COUNT + 1);
    localparam logic [c_blk_w-1:0] c_last_blk = c_blk_w'(c_n_blocks - 1);
    localparam logic [CNT_W-1:0]   c_thresh   = CNT_W'(ALARM_THRESH);

    function automatic logic [c_n_bits-1:0] f_pattern();
        logic [c_n_bits-1:0] p;
        for (int k = 0; k < c_n_bits; k++) begin
            p[k] = (PATTERN == 0) ? 1'b1 : (k % 2 == 0);
        end
        return p;
    endfunction

    localparam logic [c_n_bits-1:0] c_pattern = f_pattern();

    function automatic logic [c_blk_w-1:0] f_inc(input logic [c_blk_w-1:0] p);
        return (p == c_last_blk) ? '0 : p + c_blk_w'(1);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_SCRUB  = 2'd2
`ifdef BITFLIP_MON_LOC_EN
        , ST_REPORT = 2'd3
`endif
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_n_bits-1:0]    r_arr, w_arr_nxt;
    logic [c_blk_w-1:0]     r_ptr, w_ptr_nxt, r_cap_block;
    logic [SPLIT_COUNT-1:0] r_cap_mask, w_diff;
    logic [c_idx_w-1:0]     w_scan_base, w_scrub_base;
    logic                   w_capture, w_scrub;
    logic [c_pop_w-1:0]     w_pop;
    logic [CNT_W-1:0]       r_count, w_count_base, w_count_nxt;
    logic [CNT_W:0]         w_sum;
    logic                   r_alarm, w_alarm_nxt, r_busy;

    assign w_scan_base  = c_idx_w'(r_ptr) * c_idx_w'(SPLIT_COUNT);
    assign w_scrub_base = c_idx_w'(r_cap_block) * c_idx_w'(SPLIT_COUNT);
    assign w_diff       = r_arr[w_scan_base +: SPLIT_COUNT] ^ c_pattern[w_scan_base +: SPLIT_COUNT];

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_capture   = 1'b0;
        w_scrub     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (|w_diff) begin
                    w_capture = 1'b1;
`ifdef BITFLIP_MON_LOC_EN
                    w_state_nxt = ST_REPORT;
`else
                    w_state_nxt = ST_SCRUB;
`endif
                end else begin
                    w_ptr_nxt = f_inc(r_ptr);
                end
            end
`ifdef BITFLIP_MON_LOC_EN
            ST_REPORT: begin
                if (evt_ready) w_state_nxt = ST_SCRUB;
            end
`endif
            ST_SCRUB: begin
                w_scrub     = 1'b1;
                w_ptr_nxt   = f_inc(r_cap_block);
                w_state_nxt = enable ? ST_SCAN : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Injection is applied after the scrub so a coincident toggle wins.
    always_comb begin
        w_arr_nxt = r_arr;
        if (w_scrub) begin
            for (int i = 0; i < SPLIT_COUNT; i++) begin
                if (r_cap_mask[i]) begin
                    w_arr_nxt[w_scrub_base + c_idx_w'(i)] = c_pattern[w_scrub_base + c_idx_w'(i)];
                end
            end
        end
        if (inj_valid) w_arr_nxt[inj_idx] = ~w_arr_nxt[inj_idx];
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < SPLIT_COUNT; i++) begin
            w_pop = w_pop + c_pop_w'(r_cap_mask[i]);
        end
    end

    assign w_count_base = clear ? '0 : r_count;
    assign w_sum        = {1'b0, w_count_base} + (CNT_W + 1)'(w_pop);
    assign w_count_nxt  = !w_scrub ? w_count_base : (w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0]);
    assign w_alarm_nxt  = (r_alarm & ~clear) | (w_count_nxt >= c_thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_arr       <= c_pattern;
            r_ptr       <= '0;
            r_cap_block <= '0;
            r_cap_mask  <= '0;
            r_count     <= '0;
            r_alarm     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_arr   <= w_arr_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_capture) begin
                r_cap_block <= r_ptr;
                r_cap_mask  <= w_diff;
            end
            r_count <= w_count_nxt;
            r_alarm <= w_alarm_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef BITFLIP_MON_LOC_EN
    logic r_evt_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
        end else if (w_capture) begin
            r_evt_valid <= 1'b1;
        end else if (r_state == ST_REPORT && evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_block = r_cap_block;
    assign evt_mask  = r_cap_mask;
`else
    logic w_unused_evt_ready;
    assign w_unused_evt_ready = evt_ready;
    assign evt_valid = 1'b0;
    assign evt_block = '0;
    assign evt_mask  = '0;
`endif

    assign flip_count = r_count;
    assign alarm      = r_alarm;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bitflip_scrub_monitor.sv
`default_nettype none
// ============================================================================
// tb_bitflip_scrub_monitor: directed, scoreboarded bench for the scrub monitor
// (default parameters). Revision: 1.0
// ============================================================================
module tb_bitflip_scrub_monitor;

`ifdef BITFLIP_MON_LOC_EN
    localparam int LOC = 1;
`else
    localparam int LOC = 0;
`endif
    localparam int B = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        enable    = 1'b0;
    logic        clear     = 1'b0;
    logic        inj_valid = 1'b0;
    logic        evt_ready = 1'b0;
    logic [5:0]  inj_idx   = '0;
    logic        evt_valid;
    logic [2:0]  evt_block;
    logic [7:0]  evt_mask;
    logic [15:0] flip_count;
    logic        alarm;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    logic seen;

    typedef struct {
        logic [2:0]  blk;
        logic [7:0]  mask;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    bitflip_scrub_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clear      (clear),
        .inj_valid  (inj_valid),
        .inj_idx    (inj_idx),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_block  (evt_block),
        .evt_mask   (evt_mask),
        .flip_count (flip_count),
        .alarm      (alarm),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic inject(input int idx);
        inj_idx   = 6'(idx);
        inj_valid = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
    endtask

    task automatic expect_event(input int blk, input int mask, input int cnt);
        exp_t e;
        e.blk  = 3'(blk);
        e.mask = 8'(mask);
        e.cnt  = 16'(cnt);
        sb.push_back(e);
    endtask

    task automatic watch(input int n);
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            seen = seen | evt_valid;
        end
    endtask

    // Pops the oldest expectation and waits (bounded) for the DUT to deliver it.
    task automatic run_event(input int ready_delay);
        exp_t        e;
        int          n;
        logic [15:0] prev;
        e    = sb.pop_front();
        n    = 0;
        prev = flip_count;
`ifdef BITFLIP_MON_LOC_EN
        while (evt_valid !== 1'b1 && n < 2 * B) begin
            @(negedge clk);
            n++;
        end
        check("evt_valid", evt_valid, 1);
        check("evt_block", evt_block, e.blk);
        check("evt_mask", evt_mask, e.mask);
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            check("held_valid", evt_valid, 1);
            check("held_block", evt_block, e.blk);
            check("held_mask", evt_mask, e.mask);
            check("held_count", flip_count, prev);
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check("scrub_cycle_count", flip_count, prev);
        @(negedge clk);
        check("flip_count", flip_count, e.cnt);
`else
        while (flip_count === prev && n < 2 * B) begin
            @(negedge clk);
            n++;
        end
        check("flip_count", flip_count, e.cnt);
        check("evt_valid_tied", evt_valid, 0);
        check("evt_mask_tied", evt_mask, 0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, finish required");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        tick(2);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_block", evt_block, 0);
        check("rst_evt_mask", evt_mask, 0);
        check("rst_flip_count", flip_count, 0);
        check("rst_alarm", alarm, 0);
        check("rst_busy", busy, 0);
        rst_n  = 1'b1;

        // Clean sweep: four full passes without an event.
        enable = 1'b1;
        watch(4 * B);
        check("clean_no_event", seen, 0);
        check("clean_count", flip_count, 0);
        check("clean_busy", busy, 1);

        // Two bits in block 1 become one event.
        enable = 1'b0;
        tick(2);
        check("idle_busy", busy, 0);
        inject(13);
        inject(15);
        expect_event(1, 'hA0, 2);
        enable = 1'b1;
        run_event(0);
        watch(2 * B);
        check("rescan_no_event", seen, 0);
        check("rescan_count", flip_count, 2);

        // Back-pressure on a block-0 event.
        inject(0);
        expect_event(0, 'h01, 3);
        run_event(5);
        check("alarm_below", alarm, 0);

        // Alarm threshold, clear, and post-clear counting.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_count", flip_count, 0);
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = (i == 0) ? 17 : (i == 1) ? 30 : (i == 2) ? 36 : 47;
            inject(idx);
            expect_event(idx / 8, 1 << (idx % 8), i + 1);
            run_event(0);
            check("alarm_step", alarm, (i == 3));
        end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear2_count", flip_count, 0);
        check("clear2_alarm", alarm, 0);
        inject(9);
        expect_event(1, 'h02, 1);
        run_event(0);
        check("post_clear_alarm", alarm, 0);

        // clear coincident with the SCRUB of a 3-bit event (timing from reset).
        enable    = 1'b0;
        evt_ready = (LOC == 1);
        rst_n     = 1'b0;
        tick(1);
        rst_n     = 1'b1;
        inject(0);
        inject(8);
        inject(9);
        inject(10);
        enable = 1'b1;
        tick(4 + 2 * LOC);
        check("pre_clear_count", flip_count, 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_in_scrub", flip_count, 3);
        check("clear_in_scrub_alarm", alarm, 0);

        // Injection on a masked bit during SCRUB leaves it flipped.
        enable = 1'b0;
        rst_n  = 1'b0;
        tick(1);
        rst_n  = 1'b1;
        inject(3);
        enable = 1'b1;
        tick(2 + LOC);
        inject(3);
        check("scrub_inject_count", flip_count, 1);
        expect_event(0, 'h08, 2);
        run_event(0);

        // Reset with an upset pending.
`ifdef BITFLIP_MON_LOC_EN
        evt_ready = 1'b0;
        inject(5);
        for (int n = 0; n < 2 * B && evt_valid !== 1'b1; n++) @(negedge clk);
        check("pending_valid", evt_valid, 1);
`else
        inject(5);
        expect_event(0, 'h20, 3);
        run_event(0);
        inject(21);
`endif
        rst_n = 1'b0;
        #1;
        check("mid_rst_evt_valid", evt_valid, 0);
        check("mid_rst_count", flip_count, 0);
        check("mid_rst_busy", busy, 0);
        tick(1);
        rst_n = 1'b1;
        watch(3 * B);
        check("post_rst_no_event", seen, 0);
        check("post_rst_count", flip_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
